fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, and the IF/ID pipeline register.
- Consumes the stall/flush controls produced by the hazard/stall logic and the redirect targets from later stages.
- Drives the instruction-memory address and feeds decode.
- Tracks fetch-side HALT state so the debug unit can tell when the program has finished.

---
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline
// register, fetch-side HALT tracking and an enabled-cycle counter.
module fetch_stage #(
    parameter int unsigned         NB_PC     = 32,
    parameter int unsigned         NB_INSTR  = 32,
    parameter int unsigned         NB_CNT    = 32,
    parameter logic [NB_INSTR-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_stall_pc,
    input  logic                i_stall_IF_ID,
    input  logic                i_flush_IF_ID,
    input  logic                i_branch_taken,
    input  logic [NB_PC-1:0]    i_branch_target,
    input  logic                i_jump,
    input  logic [NB_PC-1:0]    i_jump_target,
    input  logic [NB_INSTR-1:0] i_instr,
    input  logic                i_WB_halt,
    output logic [NB_PC-1:0]    o_pc,
    output logic [NB_INSTR-1:0] o_IF_ID_instr,
    output logic [NB_PC-1:0]    o_IF_ID_pc4,
    output logic                o_IF_ID_valid,
    output logic                o_halt_pending,
    output logic                o_halted,
    output logic [NB_CNT-1:0]   o_cycle_count
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StHaltPend = 2'd1,
        StHalted   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NB_PC-1:0]      pc_q, pc_d, pc_plus4;
    logic [NB_INSTR-1:0]   instr_q, instr_d;
    logic [NB_PC-1:0]      pc4_q, pc4_d;
    logic                  valid_q, valid_d;
    logic [NB_CNT-1:0]     cnt_q, cnt_d;
    logic                  halt_fetched;
    logic                  to_halted;

    // Wraps modulo 2^NB_PC by construction.
    assign pc_plus4 = pc_q + NB_PC'(4);

    // A HALT only counts once it actually lands in IF/ID.
    assign halt_fetched = (state_q == StRun) && !i_flush_IF_ID && !i_stall_IF_ID &&
                          (i_instr == HALT_WORD);

    // FSM next-state: HALT detection, wrong-path recovery and final halt.
    always_comb begin
        state_d = state_q;
        if (i_enable) begin
            unique case (state_q)
                StRun: begin
                    if (i_WB_halt) begin
                        state_d = StHalted;
                    end else if (halt_fetched) begin
                        state_d = StHaltPend;
                    end
                end
                StHaltPend: begin
                    // A redirect or flush means the fetched HALT was wrong-path.
                    if (i_branch_taken || i_flush_IF_ID) begin
                        state_d = StRun;
                    end else if (i_WB_halt) begin
                        state_d = StHalted;
                    end
                end
                StHalted: state_d = StHalted;
                default:  state_d = state_q;
            endcase
        end
    end

    assign to_halted = (state_q != StHalted) && (state_d == StHalted);

    // Next-PC selection: redirects beat stalls; everything freezes once halted.
    always_comb begin
        pc_d = pc_q;
        if (i_enable && (state_q != StHalted) && !to_halted) begin
            if (i_branch_taken) begin
                pc_d = i_branch_target;
            end else if (i_jump) begin
                pc_d = i_jump_target;
            end else if ((state_q != StRun) || i_stall_pc) begin
                pc_d = pc_q;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    // IF/ID next value: flush beats stall; non-RUN fetch inserts bubbles.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (i_enable && (state_q != StHalted)) begin
            if (i_flush_IF_ID || to_halted) begin
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end else if (i_stall_IF_ID) begin
                instr_d = instr_q;
                pc4_d   = pc4_q;
                valid_d = valid_q;
            end else if (state_q != StRun) begin
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end else begin
                instr_d = i_instr;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end
    end

    // Cycle counter: counts enabled edges until the program is halted.
    always_comb begin
        cnt_d = cnt_q;
        if (i_enable && (state_q != StHalted)) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StRun;
            pc_q    <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_pc           = pc_q;
    assign o_IF_ID_instr  = instr_q;
    assign o_IF_ID_pc4    = pc4_q;
    assign o_IF_ID_valid  = valid_q;
    assign o_halt_pending = (state_q == StHaltPend);
    assign o_halted       = (state_q == StHalted);
    assign o_cycle_count  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a behavioural model.
module tb_fetch_stage;

    localparam int unsigned NB_PC    = 32;
    localparam int unsigned NB_INSTR = 32;
    localparam int unsigned NB_CNT   = 8;  // narrow so counter wrap is reachable
    localparam logic [31:0] HALT_W   = 32'hFFFFFFFF;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                stall_pc, stall_ifid, flush;
    logic                br, jmp, wb_halt;
    logic [NB_PC-1:0]    br_tgt, jmp_tgt;
    logic [NB_INSTR-1:0] instr;
    logic [NB_PC-1:0]    pc;
    logic [NB_INSTR-1:0] ifid_instr;
    logic [NB_PC-1:0]    ifid_pc4;
    logic                ifid_valid, halt_pending, halted;
    logic [NB_CNT-1:0]   cycle_count;

    fetch_stage #(
        .NB_PC    (NB_PC),
        .NB_INSTR (NB_INSTR),
        .NB_CNT   (NB_CNT),
        .HALT_WORD(HALT_W)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_enable       (en),
        .i_stall_pc     (stall_pc),
        .i_stall_IF_ID  (stall_ifid),
        .i_flush_IF_ID  (flush),
        .i_branch_taken (br),
        .i_branch_target(br_tgt),
        .i_jump         (jmp),
        .i_jump_target  (jmp_tgt),
        .i_instr        (instr),
        .i_WB_halt      (wb_halt),
        .o_pc           (pc),
        .o_IF_ID_instr  (ifid_instr),
        .o_IF_ID_pc4    (ifid_pc4),
        .o_IF_ID_valid  (ifid_valid),
        .o_halt_pending (halt_pending),
        .o_halted       (halted),
        .o_cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = running, 1 = HALT seen in fetch, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [7:0]  m_cnt;
    int          halted_steps;
    logic        no_halt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check_eq("pc", 64'(pc), 64'(m_pc));
        check_eq("ifid_instr", 64'(ifid_instr), 64'(m_instr));
        check_eq("ifid_pc4", 64'(ifid_pc4), 64'(m_pc4));
        check_eq("ifid_valid", 64'(ifid_valid), 64'(m_valid));
        check_eq("halt_pending", 64'(halt_pending), 64'(m_mode == 1));
        check_eq("halted", 64'(halted), 64'(m_mode == 2));
        check_eq("cycle_count", 64'(cycle_count), 64'(m_cnt));
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = '0;
        m_instr = '0;
        m_pc4   = '0;
        m_valid = 1'b0;
        m_cnt   = '0;
        halted_steps = 0;
    endtask

    // Apply the fetch-stage rules for one rising edge using the current inputs.
    task automatic model_edge();
        int          nxt_mode;
        logic        enters_halted;
        if (!en) return;
        nxt_mode = m_mode;
        if (m_mode == 0) begin
            if (wb_halt) nxt_mode = 2;
            else if (!flush && !stall_ifid && instr == HALT_W) nxt_mode = 1;
        end else if (m_mode == 1) begin
            if (br || flush) nxt_mode = 0;
            else if (wb_halt) nxt_mode = 2;
        end
        enters_halted = (m_mode != 2) && (nxt_mode == 2);
        if (m_mode != 2) m_cnt = m_cnt + 8'd1;
        if (m_mode != 2) begin
            if (flush || enters_halted) begin
                m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
            end else if (!stall_ifid) begin
                if (m_mode == 0) begin
                    m_instr = instr; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                end else begin
                    m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
                end
            end
        end
        if (m_mode != 2 && !enters_halted) begin
            if (br) m_pc = br_tgt;
            else if (jmp) m_pc = jmp_tgt;
            else if (m_mode == 0 && !stall_pc) m_pc = m_pc + 32'd4;
        end
        m_mode = nxt_mode;
    endtask

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 7) == 0) return 32'hFFFFFFFC;
        return $urandom() & 32'hFFFF_FFFC;
    endfunction

    task automatic randomize_inputs();
        en         = ($urandom_range(0, 99) < 85);
        stall_pc   = ($urandom_range(0, 99) < 15);
        stall_ifid = ($urandom_range(0, 99) < 15);
        flush      = ($urandom_range(0, 99) < 10);
        br         = ($urandom_range(0, 99) < 10);
        jmp        = ($urandom_range(0, 99) < 10);
        br_tgt     = rand_target();
        jmp_tgt    = rand_target();
        if (no_halt) begin
            instr   = $urandom();
            if (instr == HALT_W) instr = 32'h0000_0020;
            wb_halt = 1'b0;
        end else begin
            instr   = ($urandom_range(0, 9) == 0) ? HALT_W : $urandom();
            wb_halt = (m_mode == 1) ? ($urandom_range(0, 99) < 30)
                                    : ($urandom_range(0, 99) < 2);
        end
    endtask

    // One clock: model the edge, check outputs 1 time unit later, pick new inputs.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        randomize_inputs();
    endtask

    // Asserted between edges; outputs must clear before any clock arrives.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        no_halt = 1'b1;
        en = 1'b0; stall_pc = 1'b0; stall_ifid = 1'b0; flush = 1'b0;
        br = 1'b0; jmp = 1'b0; wb_halt = 1'b0;
        br_tgt = '0; jmp_tgt = '0; instr = 32'h0000_0020;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        randomize_inputs();

        // No HALTs: long enough that the narrow counter wraps.
        for (int i = 0; i < 400; i++) step();

        no_halt = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (m_mode == 2) halted_steps++;
            if (halted_steps > 4 || $urandom_range(0, 199) == 0) begin
                async_reset();
                randomize_inputs();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
